// File: rtl/led_cmd_arbiter_pkg.sv
// Shared types and helpers for the LED command arbiter: command/state encodings,
// the fixed requester-to-command mapping and the drop-counter ceiling.
package led_arb_pkg;

  typedef enum logic [1:0] {INC, DEC, CLR, INV} op_e;

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_e;

  localparam logic [7:0] DROP_MAX = 8'd255;

  // Requester i always issues command i mod 4.
  function automatic op_e op_of(input logic [2:0] idx);
    logic [2:0] m;
    m = idx & 3'd3;
    return op_e'(m[1:0]);
  endfunction

endpackage

// File: rtl/led_cmd_arbiter_if.sv
// Bundle between the debounced button stages (master) and the LED arbiter (slave).
interface led_cmd_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  import led_arb_pkg::*;

  // req_pulse is a one-cycle strobe with no ready: a press arriving while that
  // requester is already pending is lost (and counted as a drop when enabled).
  logic [N_REQ-1:0] req_pulse;
  logic [WIDTH-1:0] leds;
  logic [2:0]       grant_id;
  logic             busy;
  logic             wrap;
  logic [7:0]       drop_cnt;
  state_e           state;

  modport master (output req_pulse, input leds, grant_id, busy, wrap, drop_cnt, state);
  modport slave  (input req_pulse, output leds, grant_id, busy, wrap, drop_cnt, state);

endinterface

// File: rtl/led_cmd_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest pending index at or after ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [2:0]       ptr,
  output logic             valid,
  output logic [2:0]       win
);

  int c;

  // Walk the search order backwards so the earliest hit is written last.
  always_comb begin
    valid = 1'b0;
    win   = 3'd0;
    c     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (pend[c]) begin
        valid = 1'b1;
        win   = 3'(c);
      end
    end
  end

endmodule

// File: rtl/led_cmd_arbiter.sv
// Round-robin arbiter applying button commands to a shared LED register with hold-off.
// Optional dropped-press counter compiled in with LED_ARB_DROP_CNT_EN.
module led_cmd_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int COOLDOWN = 27000
) (
  input  logic              clk,
  input  logic              rst,
  led_cmd_arbiter_if.slave  bus
);

  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  state_e           state, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [N_REQ-1:0] pending_q, pending_n, clear_vec;
  logic [2:0]       ptr_q, ptr_n, grant_q, grant_n;
  logic [WIDTH-1:0] leds_q, leds_n;
  logic             wrap_q, wrap_n, busy_q;
  logic             pick_valid;
  logic [2:0]       pick_idx;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .pend  (pending_q),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .win   (pick_idx)
  );

  // A press landing on the clearing edge re-arms the bit instead of being lost.
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      clear_vec[i] = (state == APPLY) && (grant_q == 3'(i));
    pending_n = (pending_q & ~clear_vec) | bus.req_pulse;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    grant_n = grant_q;
    ptr_n   = ptr_q;
    leds_n  = leds_q;
    wrap_n  = wrap_q;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_n = pick_idx;
          state_n = APPLY;
        end
      end
      APPLY: begin
        case (op_of(grant_q))
          INC: begin
            leds_n = leds_q + WIDTH'(1);
            if (&leds_q) wrap_n = 1'b1;
          end
          DEC: begin
            leds_n = leds_q - WIDTH'(1);
            if (leds_q == '0) wrap_n = 1'b1;
          end
          CLR:     leds_n = '0;
          default: leds_n = ~leds_q;
        endcase
        ptr_n = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
        if (COOLDOWN == 0) begin
          state_n = IDLE;
        end else begin
          state_n = HOLD;
          cnt_n   = CW'(COOLDOWN - 1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_n = IDLE;
        else             cnt_n   = cnt_q - CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      ptr_q     <= 3'd0;
      grant_q   <= 3'd0;
      leds_q    <= '0;
      wrap_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt_q     <= cnt_n;
      pending_q <= pending_n;
      ptr_q     <= ptr_n;
      grant_q   <= grant_n;
      leds_q    <= leds_n;
      wrap_q    <= wrap_n;
      busy_q    <= (state_n != IDLE);
    end
  end

`ifdef LED_ARB_DROP_CNT_EN
  logic [N_REQ-1:0] drop_vec;
  logic [3:0]       drop_k;
  logic [8:0]       drop_sum;
  logic [7:0]       drop_q, drop_n;

  // Several requesters can drop in the same cycle; add them all, then saturate.
  always_comb begin
    drop_vec = bus.req_pulse & pending_q & ~clear_vec;
    drop_k   = 4'd0;
    for (int i = 0; i < N_REQ; i++)
      drop_k = drop_k + 4'(drop_vec[i]);
    drop_sum = {1'b0, drop_q} + {5'd0, drop_k};
    drop_n   = (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 8'd0;
    else     drop_q <= drop_n;
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = 8'd0;
`endif

  assign bus.leds     = leds_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.wrap     = wrap_q;
  assign bus.state    = state;

endmodule
